div_clk_monitor: RTL



---
 rtl/div_mon_pkg.sv | 23 ++
 rtl/dual_edge_sampler.sv | 46 ++++
 rtl/div_clk_monitor.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/div_mon_pkg.sv
// Shared types and constants for the divided-clock monitor.
// Expected period/high-time helpers take the division ratio as argument.
package div_mon_pkg;

  typedef enum logic [1:0] {
    SEEK    = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } mon_state_e;

  localparam int DEF_DIV    = 5;
  localparam int EXP_PERIOD = 2 * DEF_DIV;
  localparam int EXP_HIGH   = DEF_DIV;

  function automatic int exp_period(input int div);
    return 2 * div;
  endfunction

  function automatic int exp_high(input int div);
    return div;
  endfunction

endpackage

// File: rtl/dual_edge_sampler.sv
// Captures clk_div on both clkin edges and presents each (negedge, posedge)
// sample pair together, in time order, to the posedge domain.
module dual_edge_sampler (
  input  logic clkin,
  input  logic rst,
  input  logic clk_div,
  output logic s_n,
  output logic s_p,
  output logic s_vld
);

  logic neg_q;
  logic neg_vld_q;
  logic smp_n_q;
  logic smp_p_q;
  logic smp_vld_q;

  // Falling-edge capture; the valid flag marks the first real post-reset sample
  always_ff @(negedge clkin or posedge rst) begin
    if (rst) begin
      neg_q     <= 1'b0;
      neg_vld_q <= 1'b0;
    end else begin
      neg_q     <= clk_div;
      neg_vld_q <= 1'b1;
    end
  end

  // Pair the preceding negedge sample with the current posedge sample
  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      smp_n_q   <= 1'b0;
      smp_p_q   <= 1'b0;
      smp_vld_q <= 1'b0;
    end else begin
      smp_n_q   <= neg_q;
      smp_p_q   <= clk_div;
      smp_vld_q <= neg_vld_q;
    end
  end

  assign s_n   = smp_n_q;
  assign s_p   = smp_p_q;
  assign s_vld = smp_vld_q;

endmodule

// File: rtl/div_clk_monitor.sv
// Half-cycle resolution period/high-time checker for a clkin-derived divided
// clock: measures each period, tracks lock and counts bad periods/timeouts.
module div_clk_monitor
  import div_mon_pkg::*;
#(
  parameter int DIV      = DEF_DIV,
  parameter int CNT_W    = 8,
  parameter int LOCK_CNT = 4
) (
  input  logic             clkin,
  input  logic             rst,
  input  logic             clk_div,
  input  logic             clr_err,
  output logic             locked,
  output logic             meas_valid,
  output logic [CNT_W-1:0] period_hc,
  output logic [CNT_W-1:0] high_hc,
  output logic             err_sticky,
  output logic [7:0]       err_cnt
);

  localparam int GOOD_W = $clog2(LOCK_CNT + 1);
  localparam logic [CNT_W-1:0]  ZERO      = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  ONE       = CNT_W'(1);
  localparam logic [CNT_W-1:0]  TWO       = CNT_W'(2);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  PER_EXP   = CNT_W'(exp_period(DIV));
  localparam logic [CNT_W-1:0]  HI_EXP    = CNT_W'(exp_high(DIV));
  localparam logic [GOOD_W-1:0] GOOD_ZERO = {GOOD_W{1'b0}};
  localparam logic [GOOD_W-1:0] GOOD_LOCK = GOOD_W'(LOCK_CNT);

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {{(CNT_W-1){1'b0}}, b};
    return s[CNT_W] ? CNT_MAX : s[CNT_W-1:0];
  endfunction

  logic s_n, s_p, s_vld;

  mon_state_e        state_q, state_d;
  logic              last_q, last_d;
  logic              prim_q, prim_d;
  logic [CNT_W-1:0]  hc_q, hc_d, hi_q, hi_d;
  logic [GOOD_W-1:0] good_q, good_d, good_inc;
  logic [CNT_W-1:0]  period_q, period_d, high_q, high_d;
  logic              meas_q, meas_d, locked_q, locked_d;
  logic              sticky_q, sticky_d, sticky_base;
  logic [7:0]        err_q, err_d, err_base;

  logic              edge_a, edge_b, rise, good_per, tmo, err_evt;
  logic [1:0]        pair_hi;
  logic [CNT_W-1:0]  close_hc, close_hi, new_hc, new_hi;

  dual_edge_sampler u_sampler (
    .clkin   (clkin),
    .rst     (rst),
    .clk_div (clk_div),
    .s_n     (s_n),
    .s_p     (s_p),
    .s_vld   (s_vld)
  );

  // Edge detection, period bookkeeping, FSM next state and error update
  always_comb begin
    // edge_a: rise between last cycle's final sample and this cycle's first
    edge_a   = prim_q & ~last_q & s_n;
    edge_b   = ~s_n & s_p;
    rise     = edge_a | edge_b;
    pair_hi  = {1'b0, s_n} + {1'b0, s_p};
    good_inc = good_q + GOOD_W'(1);

    if (edge_a) begin
      close_hc = hc_q;
      close_hi = hi_q;
      new_hc   = TWO;
      new_hi   = s_p ? TWO : ONE;
    end else if (edge_b) begin
      close_hc = sat_add(hc_q, 2'd1);
      close_hi = hi_q;
      new_hc   = ONE;
      new_hi   = ONE;
    end else begin
      close_hc = hc_q;
      close_hi = hi_q;
      new_hc   = sat_add(hc_q, 2'd2);
      new_hi   = sat_add(hi_q, pair_hi);
    end

    good_per = (close_hc == PER_EXP) && (close_hi == HI_EXP);
    tmo      = !rise && (new_hc == CNT_MAX);

    state_d  = state_q;
    last_d   = last_q;
    prim_d   = prim_q;
    hc_d     = hc_q;
    hi_d     = hi_q;
    good_d   = good_q;
    period_d = period_q;
    high_d   = high_q;
    meas_d   = 1'b0;
    locked_d = locked_q;
    err_evt  = 1'b0;

    if (s_vld) begin
      last_d = s_p;
      prim_d = 1'b1;
      case (state_q)
        SEEK: begin
          if (rise) begin
            hc_d    = new_hc;
            hi_d    = new_hi;
            state_d = MEASURE;
          end else begin
            hc_d = ZERO;
            hi_d = ZERO;
          end
        end
        MEASURE, LOCKED: begin
          if (rise) begin
            hc_d     = new_hc;
            hi_d     = new_hi;
            meas_d   = 1'b1;
            period_d = close_hc;
            high_d   = close_hi;
            if (good_per) begin
              if (state_q == LOCKED) begin
                locked_d = 1'b1;
              end else if (good_inc >= GOOD_LOCK) begin
                good_d   = good_inc;
                state_d  = LOCKED;
                locked_d = 1'b1;
              end else begin
                good_d = good_inc;
              end
            end else begin
              good_d   = GOOD_ZERO;
              locked_d = 1'b0;
              state_d  = MEASURE;
              err_evt  = 1'b1;
            end
          end else if (tmo) begin
            hc_d     = ZERO;
            hi_d     = ZERO;
            good_d   = GOOD_ZERO;
            locked_d = 1'b0;
            state_d  = SEEK;
            err_evt  = 1'b1;
          end else begin
            hc_d = new_hc;
            hi_d = new_hi;
          end
        end
        default: begin
          hc_d     = ZERO;
          hi_d     = ZERO;
          good_d   = GOOD_ZERO;
          locked_d = 1'b0;
          state_d  = SEEK;
        end
      endcase
    end else begin
      meas_d = 1'b0;
    end

    // A clear in the same cycle as an error leaves exactly that one error
    err_base    = clr_err ? 8'd0 : err_q;
    sticky_base = clr_err ? 1'b0 : sticky_q;
    if (err_evt) begin
      err_d    = (err_base == 8'hFF) ? 8'hFF : err_base + 8'd1;
      sticky_d = 1'b1;
    end else begin
      err_d    = err_base;
      sticky_d = sticky_base;
    end
  end

  // State, counters and registered outputs
  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      state_q  <= SEEK;
      last_q   <= 1'b0;
      prim_q   <= 1'b0;
      hc_q     <= ZERO;
      hi_q     <= ZERO;
      good_q   <= GOOD_ZERO;
      period_q <= ZERO;
      high_q   <= ZERO;
      meas_q   <= 1'b0;
      locked_q <= 1'b0;
      sticky_q <= 1'b0;
      err_q    <= 8'd0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      prim_q   <= prim_d;
      hc_q     <= hc_d;
      hi_q     <= hi_d;
      good_q   <= good_d;
      period_q <= period_d;
      high_q   <= high_d;
      meas_q   <= meas_d;
      locked_q <= locked_d;
      sticky_q <= sticky_d;
      err_q    <= err_d;
    end
  end

  assign locked     = locked_q;
  assign meas_valid = meas_q;
  assign period_hc  = period_q;
  assign high_hc    = high_q;
  assign err_sticky = sticky_q;
  assign err_cnt    = err_q;

endmodule
